// File: rtl/ddsm_pkg.sv
// rtl/ddsm_pkg.sv - shared DDSM types and constants
package ddsm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ddsm_state_t;

  localparam int DDSM_DEF_WIDTH = 16;

  // Dither LFSR: x^15 + x^14 + 1, Fibonacci form
  localparam int LFSR_W      = 15;
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;

endpackage

// File: rtl/ddsm_lfsr_dither.sv
// rtl/ddsm_lfsr_dither.sv - 1-bit LFSR dither source with enable and reset seed
module ddsm_lfsr_dither
  import ddsm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [LFSR_W-1:0] i_seed,
  output logic              o_dither
);

  logic [LFSR_W-1:0] lfsr;
  logic              fb;

  assign fb = lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr     <= i_seed;
      o_dither <= 1'b0;
    end else begin
      // Output samples the pre-shift state, so the seed LSB is the first bit out
      o_dither <= lfsr[0] & i_en;
      if (i_en) begin
        lfsr <= {lfsr[LFSR_W-2:0], fb};
      end
    end
  end

endmodule

// File: rtl/ddsm_input_stage.sv
// rtl/ddsm_input_stage.sv - DDSM front end: FCW handshake, shadow/active registers, dither
module ddsm_input_stage
  import ddsm_pkg::*;
#(
  parameter int                P_WIDTH      = DDSM_DEF_WIDTH,
  parameter int                P_UPD_PERIOD = 8,
  parameter logic [LFSR_W-1:0] P_LFSR_SEED  = 15'h0001
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fcw_valid,
  input  logic [P_WIDTH-1:0] i_fcw,
  output logic               o_fcw_ready,
  input  logic               i_dither_en,
  output logic [P_WIDTH-1:0] o_fcw,
  output logic               o_dither,
  output logic               o_upd_pulse,
  output logic               o_busy
);

  localparam int CW = (P_UPD_PERIOD > 1) ? $clog2(P_UPD_PERIOD) : 1;

  ddsm_state_t        state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [P_WIDTH-1:0] shadow;
  logic               boundary;
  logic               load_shadow;
  logic               xfer;

  assign boundary = (cnt == CW'(P_UPD_PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acceptance only from IDLE, so a word taken on a boundary waits a full period
  always_comb begin
    state_nxt   = state;
    o_fcw_ready = 1'b0;
    load_shadow = 1'b0;
    xfer        = 1'b0;
    case (state)
      ST_IDLE: begin
        o_fcw_ready = i_rst_n;
        if (i_fcw_valid) begin
          load_shadow = 1'b1;
          state_nxt   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          xfer      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shadow      <= '0;
      o_fcw       <= '0;
      o_upd_pulse <= 1'b0;
    end else begin
      o_upd_pulse <= xfer;
      if (load_shadow) begin
        shadow <= i_fcw;
      end
      if (xfer) begin
        o_fcw <= shadow;
      end
    end
  end

  assign o_busy = (state == ST_PEND);

  ddsm_lfsr_dither u_dither (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_dither_en),
    .i_seed   (P_LFSR_SEED),
    .o_dither (o_dither)
  );

endmodule

// File: tb/tb_ddsm_input_stage.sv
// tb/tb_ddsm_input_stage.sv - self-checking bench for ddsm_input_stage
module tb_ddsm_input_stage;

  localparam int P   = 8;
  localparam int HN  = 40000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_fcw_valid;
  logic [15:0] i_fcw;
  logic        o_fcw_ready;
  logic        i_dither_en;
  logic [15:0] o_fcw;
  logic        o_dither;
  logic        o_upd_pulse;
  logic        o_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  ddsm_input_stage #(
    .P_WIDTH      (16),
    .P_UPD_PERIOD (P),
    .P_LFSR_SEED  (15'h0001)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_fcw_valid (i_fcw_valid),
    .i_fcw       (i_fcw),
    .o_fcw_ready (o_fcw_ready),
    .i_dither_en (i_dither_en),
    .o_fcw       (o_fcw),
    .o_dither    (o_dither),
    .o_upd_pulse (o_upd_pulse),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Dither bit stream b[n] = b[n-15] ^ b[n-14]; h[n+14] holds b[n]
  bit h [0:HN-1];

  // Reference model: time since reset, pending word and its due boundary
  int          m_abs;
  bit          m_pend;
  int          m_due;
  logic [15:0] m_shadow;
  logic [15:0] m_fcw;
  bit          m_pulse;
  bit          m_dither;
  int          m_idx;
  bit          m_rst;

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] w;
    logic [15:0] e_fcw;
    logic        e_pulse;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [15:0] w,
                       input logic en, output bit acc);
    int b;
    i_rst_n     = rst;
    i_fcw_valid = v;
    i_fcw       = w;
    i_dither_en = en;
    acc = rst && !m_pend && v;
    if (!rst) begin
      m_abs = 0; m_pend = 0; m_shadow = '0; m_fcw = '0;
      m_pulse = 0; m_dither = 0; m_idx = 0;
    end else begin
      m_pulse = 0;
      if (m_pend && m_abs == m_due) begin
        m_fcw   = m_shadow;
        m_pulse = 1;
        m_pend  = 0;
      end else if (!m_pend && v) begin
        m_shadow = w;
        m_pend   = 1;
        b = m_abs + (P - 1 - (m_abs % P));
        if (b == m_abs) b = b + P;
        m_due = b;
      end
      m_dither = h[m_idx + 14] & en;
      if (en) m_idx++;
      m_abs++;
    end
    m_rst = rst;
    @(posedge i_clk);
    #1;
    chk("fcw",    32'(o_fcw),       32'(m_fcw));
    chk("pulse",  32'(o_upd_pulse), 32'(m_pulse));
    chk("busy",   32'(o_busy),      32'(m_pend));
    chk("ready",  32'(o_fcw_ready), 32'(m_rst && !m_pend));
    chk("dither", 32'(o_dither),    32'(m_dither));
  endtask

  initial begin
    vec_t        tbl [$];
    bit          acc;
    logic [15:0] q [$];
    int          ptime [$];
    logic [15:0] pval [$];
    logic [15:0] seed;
    int          npulse;

    i_rst_n = 1'b0; i_fcw_valid = 1'b0; i_fcw = '0; i_dither_en = 1'b0;
    m_pend = 0; m_abs = 0; m_idx = 0;

    seed = 16'h0001;
    for (int k = 0; k < 15; k++) h[14 - k] = seed[k];
    for (int i = 15; i < HN; i++) h[i] = h[i-15] ^ h[i-14];

    // Hand-derived vectors: accept 1234 at counter 2, ABCD at counter 7
    tbl.push_back('{0, 0, 16'h0000, 16'h0000, 0, 0, 0});
    tbl.push_back('{1, 0, 16'h0000, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 0, 16'h0000, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 1, 16'h1234, 16'h0000, 0, 1, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1, 0, 16'h0000, 16'h0000, 0, 1, 0});
    tbl.push_back('{1, 0, 16'h0000, 16'h1234, 1, 0, 1});
    for (int i = 0; i < 7; i++) tbl.push_back('{1, 0, 16'h0000, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 1, 16'hABCD, 16'h1234, 0, 1, 0});
    for (int i = 0; i < 7; i++) tbl.push_back('{1, 1, 16'h5A5A, 16'h1234, 0, 1, 0});
    tbl.push_back('{1, 0, 16'h0000, 16'hABCD, 1, 0, 1});
    tbl.push_back('{1, 0, 16'h0000, 16'hABCD, 0, 0, 1});

    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].w, 1'b0, acc);
      chk($sformatf("tbl%0d_fcw", i),   32'(o_fcw),       32'(tbl[i].e_fcw));
      chk($sformatf("tbl%0d_pulse", i), 32'(o_upd_pulse), 32'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d_busy", i),  32'(o_busy),      32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ready", i), 32'(o_fcw_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_dith", i),  32'(o_dither),    32'h0);
    end

    // Back-to-back source holding valid across two words
    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    q.push_back(16'h0001);
    q.push_back(16'h0002);
    for (int i = 0; i < 30; i++) begin
      if (q.size() > 0) cycle(1'b1, 1'b1, q[0], 1'b0, acc);
      else              cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
      if (acc) void'(q.pop_front());
      if (o_upd_pulse) begin
        ptime.push_back(i);
        pval.push_back(o_fcw);
      end
    end
    chk("b2b_npulse", 32'(ptime.size()), 32'd2);
    if (ptime.size() == 2) begin
      chk("b2b_val0",    32'(pval[0]), 32'h0001);
      chk("b2b_val1",    32'(pval[1]), 32'h0002);
      chk("b2b_t0",      32'(ptime[0]), 32'd7);
      chk("b2b_spacing", 32'(ptime[1] - ptime[0]), 32'd8);
    end

    // Reset while a word is pending
    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
    cycle(1'b1, 1'b1, 16'h5555, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
    chk("rst_busy_before", 32'(o_busy), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
      if (o_upd_pulse) npulse++;
    end
    chk("rst_npulse", 32'(npulse), 32'd0);
    chk("rst_fcw",    32'(o_fcw),  32'h0);
    chk("rst_busy",   32'(o_busy), 32'd0);

    // Dither over more than a full LFSR period, with a 5-cycle enable drop
    cycle(1'b0, 1'b0, 16'h0, 1'b1, acc);
    for (int i = 0; i < 32767 + 60; i++) begin
      cycle(1'b1, 1'b0, 16'h0, !(i >= 1000 && i < 1005), acc);
      if (i == 0) chk("dither_first", 32'(o_dither), 32'd1);
      if (i >= 1000 && i < 1005) chk("dither_off", 32'(o_dither), 32'd0);
    end

    // Randomized traffic against the model
    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0),
            16'($urandom), ($urandom_range(0, 3) != 0), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ddsm_input_stage.md
Name: ddsm_input_stage

Overview:
- Front end of the DDSM datapath. Accepts a fractional control word (FCW) from the control side over a valid/ready handshake.
- Holds the accepted word in a shadow register. Transfers it to the active register only on a periodic update boundary, so the MASH core sees glitch-free, aligned word changes.
- Generates a 1-bit LFSR dither for the MASH LSB.
- Counterpart of the output stage, which registers the 4-bit network code out of the core.

Parameters:
- P_WIDTH, 16, FCW width in bits (>=4).
- P_UPD_PERIOD, 8, cycles between update boundaries (>=2).
- P_LFSR_SEED, 15'h0001, dither LFSR reset value (nonzero).

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_fcw_valid  in  1  new FCW offered
- i_fcw  in  P_WIDTH  offered FCW
- o_fcw_ready  out  1  stage can accept a word
- i_dither_en  in  1  dither enable
- o_fcw  out  P_WIDTH  active FCW to MASH core
- o_dither  out  1  dither bit to MASH LSB
- o_upd_pulse  out  1  one-cycle strobe when o_fcw changes
- o_busy  out  1  word pending in shadow register

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state=IDLE, counter=0, shadow=0, o_fcw=0, o_upd_pulse=0, o_busy=0, LFSR=P_LFSR_SEED, o_dither=0.
  - o_fcw_ready is forced 0 while i_rst_n is low.
- Boundary counter:
  - Free-running 0..P_UPD_PERIOD-1, then wraps to 0; width clog2(P_UPD_PERIOD).
  - A boundary cycle is any cycle with counter==P_UPD_PERIOD-1.
- FSM states: IDLE, PEND.
  - IDLE: o_fcw_ready=1. If i_fcw_valid, then shadow<=i_fcw and next state is PEND.
  - PEND: o_fcw_ready=0; o_busy=1 (registered, equals state==PEND). i_fcw_valid is ignored and the word is not consumed; the source must hold it.
  - PEND at a boundary cycle: o_fcw<=shadow, o_upd_pulse<=1 for the following cycle only, next state is IDLE.
- Simultaneous accept and boundary: a word accepted in IDLE on a boundary cycle is NOT applied at that boundary; it waits for the next one.
  - Latency from accept to o_fcw change is P_UPD_PERIOD cycles (accept on boundary) up to 1 cycle (accept one cycle before boundary), counted to the cycle o_fcw shows the new value.
- Equal words: an accepted word equal to the current o_fcw still produces o_upd_pulse.
- Back-to-back traffic: after a transfer, o_fcw_ready=1 in the same cycle o_upd_pulse=1, so at most one word is applied per boundary.
- Dither:
  - 15-bit Fibonacci LFSR, polynomial x^15+x^14+1, shifts every cycle when i_dither_en=1 and holds when 0.
  - o_dither is registered: lfsr[0] & i_dither_en.
- Reset mid-operation: a pending shadow word is discarded; o_fcw returns to 0; no o_upd_pulse is emitted.
- Arithmetic: the FCW is passed through unchanged, with no width extension. LFSR and counter are unsigned and wrap modulo their width.

Decomposition:
- Shared ddsm package holds:
  - FSM state encoding (IDLE=1'b0, PEND=1'b1)
  - LFSR width constant 15 and tap positions 14/13
  - default P_WIDTH
- One sub-module: ddsm_lfsr_dither (enable, seed, 1-bit output), reusable by later DDSM stages.
- The boundary counter and FSM stay inline.

Test Plan:
- Reset release, P_UPD_PERIOD=8, no traffic -> o_fcw=0, o_upd_pulse never high, o_fcw_ready=1 from first post-reset cycle, o_dither=0 with i_dither_en=0.
- i_fcw=16'h1234 accepted at counter=2 -> o_busy=1 next cycle; o_fcw=16'h1234 and o_upd_pulse=1 in the cycle after counter=7; o_fcw_ready=1 again that cycle.
- Accept 16'hABCD exactly at counter=7 -> no change at that boundary; o_fcw=16'hABCD only after the next counter=7, 8 cycles later.
- Valid held with 16'h0001 then 16'h0002 back-to-back -> one word per boundary; o_fcw sequence 0001, 0002 on consecutive boundaries, 8 cycles apart, with two o_upd_pulse strobes.
- i_dither_en=1 from reset, seed 15'h0001 -> o_dither bit stream matches the reference model for x^15+x^14+1; dropping enable for 5 cycles freezes the LFSR and forces o_dither=0; period check 32767.
- Accept 16'h5555, assert i_rst_n=0 at counter=5 before the boundary -> o_fcw stays 0, o_busy=0, no pulse after reset.
